// File: rtl/disp_bcd_scan_pkg.sv
// Shared types, widths and segment codes for the BCD display scanner.
// Holds the converter state encoding and the digit-to-segment table.
package disp_bcd_scan_pkg;

  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_W      = 20;
  localparam int unsigned BCD_DIGITS = BCD_W / 4;
  localparam int unsigned DIGITS     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_e;

  // Active-high {dp,g,f,e,d,c,b,a}; entry k is the code for decimal digit k.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] code;
    code = SEG_BLANK;
    if (d <= 4'd9) begin
      code = SEG_TABLE[d];
    end
    return code;
  endfunction

  // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_bcd_scan_bin2bcd.sv
// Sequential double-dabble converter: one iteration per clock, 16 iterations,
// then a single DONE cycle; done pulses on the edge leaving DONE.
module bin2bcd_seq
  import disp_bcd_scan_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned SHIFT_W = BCD_W + BIN_W;

  conv_state_e        state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [SHIFT_W-1:0] adjusted;
  logic [3:0]         cnt_q, cnt_d;
  logic               done_q, done_d;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    adjusted = {dabble_adjust(shift_q[SHIFT_W-1:BIN_W]), shift_q[BIN_W-1:0]};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = {{BCD_W{1'b0}}, bin};
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = {adjusted[SHIFT_W-2:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  // Raw result field; only meaningful to the consumer while done is high.
  assign bcd  = shift_q[SHIFT_W-1:BIN_W];

endmodule

// File: rtl/disp_bcd_scan.sv
// Eight-digit multiplexed 7-segment driver: converts value to BCD on change,
// then scans digits with optional leading-zero blanking.
module disp_bcd_scan
  import disp_bcd_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_LEAD = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  output logic [7:0]       seg,
  output logic [7:0]       an,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FLAT_W = DIGITS * 4;

  logic [BIN_W-1:0]  last_value_q;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [BCD_W-1:0]  bcd_q;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        an_q, an_d;

  logic [FLAT_W-1:0] digits_flat;
  logic [FLAT_W-1:0] upper;
  logic [3:0]        digit_sel;
  logic              blank;

  // Restart only from idle so a value changing mid-conversion is re-compared later.
  assign conv_start = !conv_busy && (value != last_value_q);

  bin2bcd_seq u_conv (
    .clock (clock),
    .rst   (rst),
    .start (conv_start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_value_q <= '0;
      bcd_q        <= '0;
    end else begin
      if (conv_start) begin
        last_value_q <= value;
      end
      if (conv_done) begin
        bcd_q <= conv_bcd;
      end
    end
  end

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Digits above the BCD width read as zero.
  always_comb begin
    digits_flat = {{(FLAT_W - BCD_W){1'b0}}, bcd_q};
    upper       = digits_flat >> {idx_q, 2'b00};
    digit_sel   = upper[3:0];
    blank       = (BLANK_LEAD != 0) && (idx_q != 3'd0) && (upper == '0);
    seg_d       = blank ? SEG_BLANK : seg_code(digit_sel);
    an_d        = 8'b1 << idx_q;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
      idx_q <= 3'd0;
      seg_q <= SEG_TABLE[0];
      an_q  <= 8'h01;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = conv_busy;

endmodule

// File: tb/tb_disp_bcd_scan.sv
// Directed bench for disp_bcd_scan: two instances (SCAN_DIV=4 blanking on,
// SCAN_DIV=2 blanking off) share clock, reset and value.
module tb_disp_bcd_scan;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic [15:0] value = 16'd0;

  logic [7:0]  seg_a, an_a, seg_b, an_b;
  logic [19:0] bcd_a, bcd_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int ncyc;

  always #5 clock = ~clock;

  // Edges since reset release; the scan position is a function of this count.
  always @(posedge clock or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  disp_bcd_scan #(.SCAN_DIV(4), .BLANK_LEAD(1)) dut_a (
    .clock (clock),
    .rst   (rst),
    .value (value),
    .seg   (seg_a),
    .an    (an_a),
    .bcd   (bcd_a),
    .busy  (busy_a)
  );

  disp_bcd_scan #(.SCAN_DIV(2), .BLANK_LEAD(0)) dut_b (
    .clock (clock),
    .rst   (rst),
    .value (value),
    .seg   (seg_b),
    .an    (an_b),
    .bcd   (bcd_b),
    .busy  (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int idx_exp(input int div);
    return (ncyc == 0) ? 0 : ((ncyc - 1) / div) % 8;
  endfunction

  // Expected segments packed {digit7,...,digit0}.
  task automatic scan_check(input string name, input logic [63:0] exp_a,
                            input logic [63:0] exp_b, input int n);
    int ia;
    int ib;
    for (int k = 0; k < n; k++) begin
      tick();
      ia = idx_exp(4);
      ib = idx_exp(2);
      check({name, "/an_a"}, {24'd0, an_a}, 32'd1 << ia);
      check({name, "/seg_a"}, {24'd0, seg_a}, {24'd0, exp_a[8*ia +: 8]});
      check({name, "/an_b"}, {24'd0, an_b}, 32'd1 << ib);
      check({name, "/seg_b"}, {24'd0, seg_b}, {24'd0, exp_b[8*ib +: 8]});
      check({name, "/busy_a"}, {31'd0, busy_a}, 32'd0);
    end
  endtask

  task automatic run_conv(input string name, input logic [15:0] v,
                          input logic [19:0] old_bcd, input logic [19:0] exp_bcd);
    value = v;
    tick();
    for (int k = 0; k <= 16; k++) begin
      check({name, "/busy_a"}, {31'd0, busy_a}, 32'd1);
      check({name, "/busy_b"}, {31'd0, busy_b}, 32'd1);
      check({name, "/hold_a"}, {12'd0, bcd_a}, {12'd0, old_bcd});
      if (k < 16) tick();
    end
    tick();
    check({name, "/idle_a"}, {31'd0, busy_a}, 32'd0);
    check({name, "/pre_a"}, {12'd0, bcd_a}, {12'd0, old_bcd});
    tick();
    check({name, "/bcd_a"}, {12'd0, bcd_a}, {12'd0, exp_bcd});
    check({name, "/bcd_b"}, {12'd0, bcd_b}, {12'd0, exp_bcd});
  endtask

  initial begin
    // Reset with value 0
    repeat (3) tick();
    check("rst/an_a", {24'd0, an_a}, 32'h01);
    check("rst/seg_a", {24'd0, seg_a}, 32'h3F);
    check("rst/bcd_a", {12'd0, bcd_a}, 32'h0);
    check("rst/busy_a", {31'd0, busy_a}, 32'd0);
    check("rst/an_b", {24'd0, an_b}, 32'h01);
    check("rst/seg_b", {24'd0, seg_b}, 32'h3F);
    rst = 1'b1;
    scan_check("zero", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F},
               {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}, 40);
    check("zero/bcd_a", {12'd0, bcd_a}, 32'h0);

    run_conv("v12345", 16'd12345, 20'h00000, 20'h12345);
    scan_check("s12345", {8'h00, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D},
               {8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D}, 40);

    run_conv("v65535", 16'd65535, 20'h12345, 20'h65535);
    scan_check("s65535", {8'h00, 8'h00, 8'h00, 8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D},
               {8'h3F, 8'h3F, 8'h3F, 8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D}, 40);

    run_conv("v9", 16'd9, 20'h65535, 20'h00009);
    scan_check("s9", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6F},
               {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h6F}, 40);

    // 100 then 200 mid-conversion: 200 is ignored until idle, then re-captured
    value = 16'd100;
    tick();
    repeat (5) tick();
    value = 16'd200;
    repeat (11) tick();
    check("chg/busy16", {31'd0, busy_a}, 32'd1);
    tick();
    check("chg/idle17", {31'd0, busy_a}, 32'd0);
    check("chg/hold17", {12'd0, bcd_a}, 32'h00009);
    tick();
    check("chg/bcd100", {12'd0, bcd_a}, 32'h00100);
    check("chg/recap", {31'd0, busy_a}, 32'd1);
    for (int k = 0; k < 17; k++) begin
      tick();
      check("chg/hold100", {12'd0, bcd_a}, 32'h00100);
    end
    check("chg/idle2", {31'd0, busy_a}, 32'd0);
    tick();
    check("chg/bcd200_a", {12'd0, bcd_a}, 32'h00200);
    check("chg/bcd200_b", {12'd0, bcd_b}, 32'h00200);

    // Reset during SHIFT for 777
    value = 16'd777;
    tick();
    repeat (5) tick();
    check("abort/busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort/bcd_a", {12'd0, bcd_a}, 32'h0);
    check("abort/an_a", {24'd0, an_a}, 32'h01);
    check("abort/seg_a", {24'd0, seg_a}, 32'h3F);
    check("abort/busy_a", {31'd0, busy_a}, 32'd0);
    check("abort/bcd_b", {12'd0, bcd_b}, 32'h0);
    tick();
    check("abort/hold", {12'd0, bcd_a}, 32'h0);
    rst = 1'b1;
    run_conv("v777", 16'd777, 20'h00000, 20'h00777);
    scan_check("s777", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07, 8'h07},
               {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h07, 8'h07, 8'h07}, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
